median_frame_sequencer: RTL and testbench

Frame-level controller for the median-filter/histogram datapath. It loads one binary frame from a host pixel stream into the binary image memory, owns the memory port mux between host and filter, and pulses the filter start. It then waits for filter completion, triggers and drains the histogram read-out, clears the histogram, and reports frame completion. It sits between the host interface and the histogram top, one instance per datapath.

---
 rtl/median_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/median_frame_sequencer.sv
// Frame-level controller: loads a binary frame into image memory, kicks the median
// filter, drains and clears the histogram, and guards each wait with a watchdog.
module median_frame_sequencer #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 180,
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 4_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              pixelValid,
  input  logic              pixelData,
  output logic              pixelReady,
  output logic [ADDR_W-1:0] memXAddress,
  output logic [ADDR_W-1:0] memYAddress,
  output logic              memDataOut,
  output logic              memWrite,
  output logic              memSelFilter,
  output logic              start,
  input  logic              filterReady,
  input  logic              filterDone,
  output logic              readHistogram,
  output logic              clearHistogram,
  input  logic              xValid,
  input  logic              yValid,
  input  logic              histogramClear,
  output logic              busy,
  output logic              frameDone,
  output logic              error,
  output logic [3:0]        state
);

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int BEAT_W = ADDR_W + 1;  // beat counts must be able to hold 2^ADDR_W

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_HEIGHT - 1);
  localparam logic [BEAT_W-1:0] X_FULL = BEAT_W'(IMG_WIDTH);
  localparam logic [BEAT_W-1:0] Y_FULL = BEAT_W'(IMG_HEIGHT);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    START     = 4'd2,
    FILTER    = 4'd3,
    HIST_REQ  = 4'd4,
    HIST_READ = 4'd5,
    CLEAR     = 4'd6,
    DONE      = 4'd7,
    ERROR     = 4'd8
  } seqState_t;

  seqState_t         curState, nextState;
  logic [ADDR_W-1:0] xCount, yCount, xNext, yNext;
  logic [BEAT_W-1:0] xBeats, yBeats, xBeatsNext, yBeatsNext;
  logic [WD_W-1:0]   wdCount, wdNext;
  logic              wdExpired;

  assign wdExpired = (wdCount == WD_LAST);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    nextState  = curState;
    xNext      = xCount;
    yNext      = yCount;
    xBeatsNext = xBeats;
    yBeatsNext = yBeats;
    wdNext     = '0;

    unique case (curState)
      IDLE: begin
        if (frameStart) begin
          nextState = LOAD;
          xNext     = '0;
          yNext     = '0;
        end
      end
      LOAD: begin
        // y is the inner index: columns are written top to bottom
        if (pixelValid) begin
          if (yCount == Y_LAST) begin
            yNext = '0;
            if (xCount == X_LAST) begin
              xNext     = '0;
              nextState = START;
            end else begin
              xNext = xCount + 1'b1;
            end
          end else begin
            yNext = yCount + 1'b1;
          end
        end
      end
      START: begin
        if (filterReady)    nextState = FILTER;
        else if (wdExpired) nextState = ERROR;
      end
      FILTER: begin
        if (filterDone)     nextState = HIST_REQ;
        else if (wdExpired) nextState = ERROR;
      end
      HIST_REQ: begin
        nextState  = HIST_READ;
        xBeatsNext = '0;
        yBeatsNext = '0;
      end
      HIST_READ: begin
        if (xValid && (xBeats != X_FULL)) xBeatsNext = xBeats + 1'b1;
        if (yValid && (yBeats != Y_FULL)) yBeatsNext = yBeats + 1'b1;
        if ((xBeatsNext == X_FULL) && (yBeatsNext == Y_FULL)) nextState = CLEAR;
        else if (wdExpired)                                    nextState = ERROR;
      end
      CLEAR: begin
        if (histogramClear) nextState = DONE;
        else if (wdExpired) nextState = ERROR;
      end
      DONE: nextState = IDLE;
      ERROR: begin
        if (frameStart) begin
          nextState = LOAD;
          xNext     = '0;
          yNext     = '0;
        end
      end
      default: nextState = IDLE;
    endcase

    // Any state change restarts the watchdog; it only advances while stalled in a wait state.
    if ((nextState == curState) &&
        (curState inside {START, FILTER, HIST_READ, CLEAR}))
      wdNext = wdCount + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= IDLE;
      xCount   <= '0;
      yCount   <= '0;
      xBeats   <= '0;
      yBeats   <= '0;
      wdCount  <= '0;
    end else begin
      curState <= nextState;
      xCount   <= xNext;
      yCount   <= yNext;
      xBeats   <= xBeatsNext;
      yBeats   <= yBeatsNext;
      wdCount  <= wdNext;
    end
  end

  assign state          = curState;
  assign pixelReady     = (curState == LOAD);
  assign memWrite       = pixelReady & pixelValid;
  assign memDataOut     = pixelReady & pixelData;
  assign memXAddress    = xCount;
  assign memYAddress    = yCount;
  assign memSelFilter   = curState inside {START, FILTER, HIST_REQ, HIST_READ, CLEAR};
  assign start          = (curState == START) & filterReady;
  assign readHistogram  = (curState == HIST_REQ);
  assign clearHistogram = (curState == CLEAR);
  assign busy           = (curState != IDLE) && (curState != ERROR);
  assign frameDone      = (curState == DONE);
  assign error          = (curState == ERROR);

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Directed bench for median_frame_sequencer on a reduced 20x15 frame with a 100-cycle
// watchdog; a per-cycle monitor checks write addressing and output decode.
module tb_median_frame_sequencer;

  localparam int W  = 20;
  localparam int H  = 15;
  localparam int AW = 8;
  localparam int TO = 100;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frameStart = 1'b0;
  logic          pixelValid = 1'b0;
  logic          pixelData = 1'b0;
  logic          pixelReady;
  logic [AW-1:0] memXAddress, memYAddress;
  logic          memDataOut, memWrite, memSelFilter, start;
  logic          filterReady = 1'b0;
  logic          filterDone = 1'b0;
  logic          readHistogram, clearHistogram;
  logic          xValid = 1'b0;
  logic          yValid = 1'b0;
  logic          histogramClear = 1'b0;
  logic          busy, frameDone, error;
  logic [3:0]    state;

  median_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .frameStart(frameStart),
    .pixelValid(pixelValid), .pixelData(pixelData), .pixelReady(pixelReady),
    .memXAddress(memXAddress), .memYAddress(memYAddress), .memDataOut(memDataOut),
    .memWrite(memWrite), .memSelFilter(memSelFilter), .start(start),
    .filterReady(filterReady), .filterDone(filterDone),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .xValid(xValid), .yValid(yValid), .histogramClear(histogramClear),
    .busy(busy), .frameDone(frameDone), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: accepted pixel k must land at x=k/H, y=k%H; outputs must follow the state table.
  int accepted = 0, startPulses = 0, readPulses = 0, clearCycles = 0;
  int donePulses = 0, histReadCycles = 0, lastX = -1, lastY = -1, k = 0;

  always @(negedge clk) begin
    if (!reset) begin
      check("pixelReady", pixelReady, state == 4'd1);
      check("memWrite", memWrite, pixelReady & pixelValid);
      check("busy", busy, (state != 4'd0) && (state != 4'd8));
      check("error", error, state == 4'd8);
      check("memSelFilter", memSelFilter, (state >= 4'd2) && (state <= 4'd6));
      if (memWrite) begin
        k = accepted % N;
        check("memX", memXAddress, k / H);
        check("memY", memYAddress, k % H);
        check("memData", memDataOut, pixelData);
        lastX = int'(memXAddress);
        lastY = int'(memYAddress);
        accepted++;
      end
      if (start) begin
        startPulses++;
        check("start_needs_ready", filterReady, 1);
      end
      if (readHistogram)  readPulses++;
      if (clearHistogram) clearCycles++;
      if (frameDone)      donePulses++;
      if (state == 4'd5)  histReadCycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadFrame(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        pixelValid = 1'b0;
        pixelData  = 1'b1;
        tick();
      end
      pixelValid = 1'b1;
      pixelData  = 1'($urandom_range(0, 1));
      tick();
    end
    pixelValid = 1'b0;
    pixelData  = 1'b0;
  endtask

  task automatic checkAllIdle(input string name);
    check({name, "_state"}, state, 0);
    check({name, "_strobes"},
          {start, readHistogram, clearHistogram, memWrite, memSelFilter,
           pixelReady, busy, frameDone, error}, 0);
    check({name, "_addr"}, {memXAddress, memYAddress}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  int a0, s0, r0, c0, h0, d0;

  initial begin
    repeat (3) tick();
    checkAllIdle("reset");
    reset = 1'b0;

    // Frame A: continuous pixels, delayed filterReady, full histogram drain.
    frameStart = 1'b1; tick(); frameStart = 1'b0;
    check("A_load_entry", state, 1);
    a0 = accepted;
    loadFrame(1'b0);
    check("A_state_start", state, 2);
    check("A_writes", accepted - a0, 300);
    check("A_last_x", lastX, 19);
    check("A_last_y", lastY, 14);

    s0 = startPulses;
    repeat (20) tick();
    check("A_start_waiting", state, 2);
    check("A_no_early_start", startPulses - s0, 0);
    filterReady = 1'b1;
    #1 check("A_start_coincident", start, 1);
    tick();
    filterReady = 1'b0;
    check("A_filter_entry", state, 3);
    check("A_start_pulses", startPulses - s0, 1);

    r0 = readPulses;
    repeat (59) tick();
    filterDone = 1'b1; tick(); filterDone = 1'b0;
    check("A_hist_req", state, 4);
    check("A_read_req_high", readHistogram, 1);
    tick();
    check("A_hist_read", state, 5);

    // x on every cycle (past its limit), y every other cycle: both full on cycle 28.
    h0 = histReadCycles;
    for (int i = 0; i < 200 && state === 4'd5; i++) begin
      xValid = (i < W + 9);
      yValid = (i % 2 == 0);
      tick();
    end
    xValid = 1'b0;
    yValid = 1'b0;
    check("A_hist_read_cycles", histReadCycles - h0, 29);
    check("A_clear_entry", state, 6);

    c0 = clearCycles;
    repeat (4) tick();
    histogramClear = 1'b1; tick(); histogramClear = 1'b0;
    check("A_done_state", state, 7);
    check("A_frame_done_high", frameDone, 1);
    tick();
    check("A_back_idle", state, 0);
    check("A_clear_cycles", clearCycles - c0, 5);
    check("A_read_pulses", readPulses - r0, 1);
    check("A_frames_done", donePulses, 1);

    // Frame B: gapped pixels, then filter never finishes -> watchdog.
    frameStart = 1'b1; tick(); frameStart = 1'b0;
    check("B_load_entry", state, 1);
    a0 = accepted;
    loadFrame(1'b1);
    check("B_state_start", state, 2);
    check("B_writes", accepted - a0, 300);
    check("B_last_x", lastX, 19);
    check("B_last_y", lastY, 14);
    filterReady = 1'b1; tick(); filterReady = 1'b0;
    check("B_filter_entry", state, 3);
    repeat (30) tick();
    frameStart = 1'b1; tick(); frameStart = 1'b0;
    check("B_framestart_ignored", state, 3);
    repeat (68) tick();
    check("B_filter_at_99", state, 3);
    tick();
    check("B_error_at_100", state, 8);
    check("B_error_flag", error, 1);
    check("B_error_sel", memSelFilter, 0);
    check("B_error_busy", busy, 0);

    d0 = donePulses;
    frameStart = 1'b1; tick(); frameStart = 1'b0;
    check("B_recover_load", state, 1);
    check("B_recover_error", error, 0);

    // Frame C: reset while draining the histogram.
    loadFrame(1'b0);
    filterReady = 1'b1; tick(); filterReady = 1'b0;
    filterDone = 1'b1; tick(); filterDone = 1'b0;
    tick();
    check("C_hist_read", state, 5);
    xValid = 1'b1; yValid = 1'b1;
    repeat (5) tick();
    xValid = 1'b0; yValid = 1'b0;
    check("C_still_reading", state, 5);
    reset = 1'b1; tick();
    checkAllIdle("C_reset");
    reset = 1'b0;
    repeat (3) tick();
    check("C_stays_idle", state, 0);
    check("C_no_frame_done", donePulses - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
